// File: rtl/param_selection_sorter.sv
// In-place selection sorter over a DEPTH x WIDTH register array with a per-run
// ascending/descending mode, host load/read port, swap counter and done pulse.
module param_selection_sorter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             desc,
    input  logic             wr,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    output logic             ready,
    output logic             done,
    output logic [AW-1:0]    swap_count
);
    typedef enum logic [2:0] {IDLE, OUTER, INNER, CHECK, SWAP} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    i, j, m;
    logic [WIDTH-1:0] vm;
    logic             mode;
    logic [WIDTH-1:0] mem_i, mem_j;
    logic             better, i_last, j_last;

    assign mem_i  = mem[i];
    assign mem_j  = mem[j];
    assign better = mode ? (mem_j > vm) : (mem_j < vm);
    assign i_last = (i == LAST);
    assign j_last = (j == LAST);
    assign ready  = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = OUTER;
            OUTER:   state_next = i_last ? IDLE : INNER;
            INNER:   if (j_last) state_next = CHECK;
            CHECK:   state_next = (m != i) ? SWAP : OUTER;
            SWAP:    state_next = OUTER;
            default: state_next = IDLE;
        endcase
    end

    // Loop indices, running extreme, host read register and run statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataout    <= '0;
            done       <= 1'b0;
            swap_count <= '0;
        end else begin
            done <= (state == OUTER) && i_last;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode       <= desc;
                        i          <= '0;
                        swap_count <= '0;
                    end else if (!wr) begin
                        dataout <= mem[addr];
                    end
                end
                OUTER: begin
                    if (!i_last) begin
                        j  <= i + AW'(1);
                        m  <= i;
                        vm <= mem_i;
                    end
                end
                INNER: begin
                    // Strict compare keeps the earliest index on ties.
                    if (better) begin
                        m  <= j;
                        vm <= mem_j;
                    end
                    if (!j_last) j <= j + AW'(1);
                end
                CHECK: begin
                    if (m == i) i <= i + AW'(1);
                end
                SWAP: begin
                    i          <= i + AW'(1);
                    swap_count <= swap_count + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Memory is never reset; a reset cycle simply suppresses any write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == IDLE && !start && wr) begin
                mem[addr] <= datain;
            end else if (state == SWAP) begin
                mem[m] <= mem_i;
                mem[i] <= vm;
            end
        end
    end
endmodule

// File: tb/tb_param_selection_sorter.sv
// Scoreboard bench for param_selection_sorter: an 8x8 and a 4x16 instance,
// expectations queued by the stimulus and compared by one negedge monitor.
module tb_param_selection_sorter;
    typedef logic [7:0]  vec8_t [8];
    typedef logic [15:0] vec4_t [4];
    typedef struct {
        int busy;
        int swaps;
        bit aborted;
    } sort_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start8 = 1'b0, desc8 = 1'b0, wr8 = 1'b0;
    logic [2:0]  addr8 = '0;
    logic [7:0]  din8 = '0;
    logic [7:0]  dout8;
    logic        ready8, done8;
    logic [2:0]  swap8;

    logic        start4 = 1'b0, desc4 = 1'b0, wr4 = 1'b0;
    logic [1:0]  addr4 = '0;
    logic [15:0] din4 = '0;
    logic [15:0] dout4;
    logic        ready4, done4;
    logic [1:0]  swap4;

    int checks = 0;
    int errors = 0;

    logic [15:0] rq8[$];
    logic [15:0] rq4[$];
    sort_exp_t   sq8[$];
    sort_exp_t   sq4[$];
    sort_exp_t   se;
    logic [15:0] ev;
    int          busy8 = 0, busy4 = 0;

    logic rd_req8 = 1'b0, rd_req4 = 1'b0;
    logic rd_v8 = 1'b0, rd_v4 = 1'b0;
    logic reset_chk = 1'b0, mon_en = 1'b0, perm_req = 1'b0, final_req = 1'b0;
    int   perm_mask = 0;

    param_selection_sorter dut8 (
        .clk(clk), .rst(rst), .start(start8), .desc(desc8), .wr(wr8),
        .addr(addr8), .datain(din8), .dataout(dout8), .ready(ready8),
        .done(done8), .swap_count(swap8)
    );

    param_selection_sorter #(.WIDTH(16), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .desc(desc4), .wr(wr4),
        .addr(addr4), .datain(din4), .dataout(dout4), .ready(ready4),
        .done(done4), .swap_count(swap4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_v8 <= rd_req8;
        rd_v4 <= rd_req4;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: host reads, end-of-sort statistics, stray done pulses.
    always @(negedge clk) begin
        if (reset_chk) begin
            chk("rst_ready8", 32'(ready8), 1);
            chk("rst_done8", 32'(done8), 0);
            chk("rst_swap8", 32'(swap8), 0);
            chk("rst_dout8", 32'(dout8), 0);
            chk("rst_ready4", 32'(ready4), 1);
            chk("rst_done4", 32'(done4), 0);
            chk("rst_swap4", 32'(swap4), 0);
            chk("rst_dout4", 32'(dout4), 0);
        end
        if (mon_en) begin
            if (rd_v8) begin
                if (rq8.size() == 0) chk("read8_unqueued", 1, 0);
                else begin
                    ev = rq8.pop_front();
                    chk("read8", 32'(dout8), 32'(ev));
                end
            end
            if (rd_v4) begin
                if (rq4.size() == 0) chk("read4_unqueued", 1, 0);
                else begin
                    ev = rq4.pop_front();
                    chk("read4", 32'(dout4), 32'(ev));
                end
            end
            if (ready8 !== 1'b1) busy8++;
            else if (busy8 > 0) begin
                if (sq8.size() == 0) chk("sort8_unqueued", 1, 0);
                else begin
                    se = sq8.pop_front();
                    if (se.aborted) begin
                        chk("abort8_done", 32'(done8), 0);
                        chk("abort8_swaps", 32'(swap8), 0);
                    end else begin
                        chk("busy8", busy8, se.busy);
                        chk("swaps8", 32'(swap8), se.swaps);
                        chk("done8", 32'(done8), 1);
                    end
                end
                busy8 = 0;
            end else if (done8 !== 1'b0) chk("stray_done8", 32'(done8), 0);
            if (ready4 !== 1'b1) busy4++;
            else if (busy4 > 0) begin
                if (sq4.size() == 0) chk("sort4_unqueued", 1, 0);
                else begin
                    se = sq4.pop_front();
                    chk("busy4", busy4, se.busy);
                    chk("swaps4", 32'(swap4), se.swaps);
                    chk("done4", 32'(done4), 1);
                end
                busy4 = 0;
            end else if (done4 !== 1'b0) chk("stray_done4", 32'(done4), 0);
            if (perm_req) chk("perm8", perm_mask, 32'hFF);
            if (final_req) chk("queues_drained", rq8.size() + rq4.size() + sq8.size() + sq4.size(), 0);
        end
    end

    task automatic idle8();
        @(posedge clk); #1;
        wr8 = 1'b0; rd_req8 = 1'b0; start8 = 1'b0;
    endtask

    task automatic write8(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr8 = 1'b1; rd_req8 = 1'b0; addr8 = a; din8 = d;
    endtask

    task automatic read8(input logic [2:0] a, input logic [7:0] e);
        @(posedge clk); #1;
        wr8 = 1'b0; rd_req8 = 1'b1; addr8 = a;
        rq8.push_back(16'(e));
    endtask

    task automatic load8(input vec8_t v);
        for (int k = 0; k < 8; k++) write8(3'(k), v[k]);
    endtask

    task automatic start8_run(input logic d, input int busy, input int swaps, input bit ab);
        @(posedge clk); #1;
        wr8 = 1'b0; rd_req8 = 1'b0; desc8 = d; start8 = 1'b1;
        sq8.push_back('{busy, swaps, ab});
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait_idle8();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready8 !== 1'b1 && n < 300);
        if (ready8 !== 1'b1) begin
            $display("[TB] FAIL wait_idle8 actual=busy required=ready");
            $fatal(1, "[TB] timeout");
        end
    endtask

    task automatic applyStimulus(input vec8_t v, input logic d, input int busy, input int swaps);
        load8(v);
        start8_run(d, busy, swaps, 1'b0);
        wait_idle8();
    endtask

    task automatic checkOutput(input vec8_t e);
        for (int k = 0; k < 8; k++) read8(3'(k), e[k]);
        idle8();
    endtask

    task automatic write4(input logic [1:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        wr4 = 1'b1; rd_req4 = 1'b0; addr4 = a; din4 = d;
    endtask

    task automatic read4(input logic [1:0] a, input logic [15:0] e);
        @(posedge clk); #1;
        wr4 = 1'b0; rd_req4 = 1'b1; addr4 = a;
        rq4.push_back(e);
    endtask

    task automatic wait_idle4();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready4 !== 1'b1 && n < 300);
        if (ready4 !== 1'b1) begin
            $display("[TB] FAIL wait_idle4 actual=busy required=ready");
            $fatal(1, "[TB] timeout");
        end
    endtask

    initial begin
        vec8_t v, e;
        vec4_t w, f;

        repeat (3) @(posedge clk);
        #1 reset_chk = 1'b1;
        @(posedge clk); #1;
        reset_chk = 1'b0;
        rst = 1'b0;
        mon_en = 1'b1;

        $display("[TB] load and read back k+16");
        for (int k = 0; k < 8; k++) v[k] = 8'(k + 16);
        load8(v);
        checkOutput(v);

        $display("[TB] ascending sort of mixed vector");
        v = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
        e = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        applyStimulus(v, 1'b0, 49, 6);
        checkOutput(e);

        $display("[TB] descending sort of mixed vector");
        e = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        applyStimulus(v, 1'b1, 49, 6);
        checkOutput(e);

        $display("[TB] already sorted input");
        e = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        applyStimulus(e, 1'b0, 43, 0);
        checkOutput(e);

        $display("[TB] duplicates");
        v = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2};
        e = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2};
        applyStimulus(v, 1'b0, 47, 4);
        checkOutput(e);

        $display("[TB] reset mid-sort");
        v = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
        load8(v);
        start8_run(1'b0, 0, 0, 1'b1);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle8();
        perm_mask = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            addr8 = 3'(k);
            @(posedge clk); #1;
            perm_mask = perm_mask | (1 << dout8);
        end
        perm_req = 1'b1;
        @(posedge clk); #1;
        perm_req = 1'b0;
        e = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        applyStimulus(v, 1'b0, 49, 6);
        checkOutput(e);

        $display("[TB] 16x4 instance with mid-sort wr/start");
        w = '{16'hFFFF, 16'h0001, 16'h8000, 16'h0000};
        f = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF};
        for (int k = 0; k < 4; k++) write4(2'(k), w[k]);
        @(posedge clk); #1;
        wr4 = 1'b0; desc4 = 1'b0; start4 = 1'b1;
        sq4.push_back('{14, 1, 1'b0});
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (4) @(posedge clk);
        #1 wr4 = 1'b1; start4 = 1'b1; addr4 = 2'd0; din4 = 16'h1234;
        @(posedge clk); #1;
        wr4 = 1'b0; start4 = 1'b0;
        wait_idle4();
        for (int k = 0; k < 4; k++) read4(2'(k), f[k]);
        @(posedge clk); #1;
        rd_req4 = 1'b0;

        repeat (2) @(posedge clk);
        #1 final_req = 1'b1;
        @(posedge clk); #1;
        final_req = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_selection_sorter.md
# param_selection_sorter

In-place selection sorter over an internal register-array memory of DEPTH words of WIDTH bits, with a per-run ascending/descending mode. Host loads and reads words through a simple address port while idle, pulses start, and waits for ready. This is the parametrised next generation of the fixed 8x8 sorter. It adds sort direction, a swap counter, a done pulse and exact cycle accounting.

## Interface
- WIDTH, 8, data word width (≥1)
- DEPTH, 8, number of words; power of two, ≥2
- AW, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sort; sampled only in IDLE
- desc  in  1  sort mode, latched with start: 0 ascending, 1 descending
- wr  in  1  host write strobe (IDLE only)
- addr  in  AW  host word address
- datain  in  WIDTH  host write data
- dataout  out  WIDTH  registered host read data
- ready  out  1  1 = IDLE, host port active
- done  out  1  one-cycle pulse on sort completion
- swap_count  out  AW  number of swaps performed in the last sort

## Operation
- States: IDLE, OUTER, INNER, CHECK, SWAP. Internal registers: i, j, m (AW bits), vm (WIDTH bits), mode.
- IDLE:
  - If start=1: mode<=desc, i<=0, swap_count<=0, go to OUTER. start has priority, so wr is ignored that cycle.
  - Otherwise, wr=1 writes mem[addr]<=datain.
  - Otherwise, dataout<=mem[addr].
- OUTER:
  - If i==DEPTH-1: go to IDLE and pulse done.
  - Otherwise: j<=i+1, m<=i, vm<=mem[i], go to INNER.
- INNER:
  - Ascending: if mem[j]<vm (unsigned, strict), then m<=j and vm<=mem[j].
  - Descending: if mem[j]>vm (unsigned, strict), then m<=j and vm<=mem[j].
  - If j==DEPTH-1, go to CHECK. Otherwise j<=j+1.
  - Ties keep the earliest index.
- CHECK:
  - If m!=i: go to SWAP.
  - Otherwise: i<=i+1, go to OUTER.
- SWAP: mem[m]<=mem[i], mem[i]<=vm, i<=i+1, swap_count<=swap_count+1, go to OUTER. Both writes happen in the same cycle.
- Internal memory reads are combinational from the register array.
- While not IDLE:
  - start, wr, addr, datain and desc are ignored.
  - dataout holds its last value.
- swap_count holds after done until the next accepted start. Maximum value is DEPTH-1, which fits in AW bits.
- Memory contents are never reset.

## Timing
- Reset values: state IDLE, ready=1, done=0, dataout=0, swap_count=0. i/j/m/vm/mode are don't-care.
- Host read latency is 1 cycle: addr presented in cycle n gives dataout valid after edge n.
- A write followed next cycle by a read of the same address returns the new data.
- start accepted at edge E0 means ready=0 from E0 onward.
- ready stays low for exactly (DEPTH+1)(DEPTH+2)/2 − 2 + swap_count cycles. For DEPTH=8 that is 43 + swap_count.
- done=1 in the first cycle with ready=1 after a sort. It is never asserted otherwise, including after reset.
- A start held high across completion is accepted again at the first IDLE edge.
- rst during any state: next cycle is IDLE with reset output values. A SWAP coinciding with rst performs no write. Memory keeps whatever permutation it held.
- Minimum (already-sorted) run for DEPTH=8: 43 cycles. Maximum: 50.

## Test plan
- Reset, then load mem[k]=k+16 for k=0..7, read back each address -> dataout = k+16 one cycle after addr; ready=1, done=0, swap_count=0.
- Load [5,3,7,1,0,6,2,4], desc=0, pulse start -> ready low exactly 49 cycles; memory reads back 0..7; swap_count=6; done high for one cycle.
- Same load, desc=1 -> memory reads back 7,6,5,4,3,2,1,0; swap_count=6; ready low 49 cycles.
- Load 0..7, desc=0 -> swap_count=0; ready low exactly 43 cycles. Load [2,2,1,1,2,1,1,2] -> reads back [1,1,1,1,2,2,2,2].
- Start sort of [5,3,7,1,0,6,2,4], assert rst on cycle 20 -> ready=1 and swap_count=0 the next cycle, no done pulse. Memory reads back a permutation of the input. A new start sorts correctly.
- Second configuration, WIDTH=16, DEPTH=4: load [0xFFFF,0x0001,0x8000,0x0000], ascending -> [0x0000,0x0001,0x8000,0xFFFF], swap_count=1, ready low 14 cycles. Also check that wr/start pulsed mid-sort are ignored.
